// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC job arbiter and its picker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the controller state enum, datapath width, MAC pipeline latency
// and the helper used to size the per-job beat counter.
package mac_pkg;

  localparam int W           = 16;  // operand / result width, matches mac ports
  localparam int MAC_LAT     = 1;   // cycles from a/b at mac inputs to op update
  localparam int MAX_LEN_DEF = 64;  // default job length limit

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    RESP
  } state_t;

  // Beat counter must hold the value MAX_LEN itself.
  function automatic int beat_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int BEAT_W = beat_w(MAX_LEN_DEF);

  // Drain counter counts 0..MAC_LAT-1.
  localparam int DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker with a registered priority pointer.
// Latency: grant is combinational from req_i; pointer updates on the clock.
// Backpressure: none; the pointer only moves when advance_i and a request coincide.
//
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   req_i[1:0]         request lines
//   advance_i          commit the current grant; pointer moves to the loser
//   grant_o            granted index
//   grant_valid_o      at least one request present
module rr_pick2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic       grant_o,
  output logic       grant_valid_o
);

  logic ptr_q;  // requester that wins a tie

  always_comb begin
    grant_valid_o = |req_i;
    if (req_i == 2'b11) begin
      grant_o = ptr_q;
    end else begin
      grant_o = req_i[1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else if (advance_i && grant_valid_o) begin
      ptr_q <= ~grant_o;
    end
  end

endmodule

// File: rtl/mac_job_arbiter.sv
// Shares one accumulating MAC between two requesters, one whole job at a time.
// Latency: last pair accepted in cycle t -> result valid in cycle t+1+MAC_LAT.
// Backpressure: req ready only for the granted requester in STREAM; result held until res ready.
//
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   reqN_valid/ready/a/b/last   operand-pair stream from requester N
//   resN_valid/ready/data/err   job result to requester N (err = length limit hit)
//   mac_a, mac_b, mac_clr_n     drive the shared mac (clr_n is its accumulator clear)
//   mac_op                      accumulator output of the shared mac
module mac_job_arbiter
  import mac_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_last,
  output logic         res0_valid,
  input  logic         res0_ready,
  output logic [W-1:0] res0_data,
  output logic         res0_err,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_last,
  output logic         res1_valid,
  input  logic         res1_ready,
  output logic [W-1:0] res1_data,
  output logic         res1_err,
  output logic [W-1:0] mac_a,
  output logic [W-1:0] mac_b,
  output logic         mac_clr_n,
  input  logic [W-1:0] mac_op
);

  localparam int CNT_W = beat_w(MAX_LEN);

  state_t               state_q;
  logic                 gnt_q;     // 0: requester 0 owns the MAC, 1: requester 1
  logic                 err_q;
  logic [CNT_W-1:0]     beat_q;
  logic [CNT_W-1:0]     beat_d;
  logic [DRAIN_W-1:0]   drain_q;
  logic [W-1:0]         mac_a_q;
  logic [W-1:0]         mac_b_q;

  logic                 pick;
  logic                 pick_vld;

  logic                 sel_valid;
  logic                 sel_last;
  logic [W-1:0]         sel_a;
  logic [W-1:0]         sel_b;
  logic                 sel_res_ready;

  // Requests are only looked at in IDLE, so the pointer only moves there.
  rr_pick2 u_pick (
    .clk_i         (clk),
    .rst_ni        (rst),
    .req_i         ({req1_valid, req0_valid}),
    .advance_i     (state_q == IDLE),
    .grant_o       (pick),
    .grant_valid_o (pick_vld)
  );

  always_comb begin
    sel_valid     = gnt_q ? req1_valid : req0_valid;
    sel_last      = gnt_q ? req1_last  : req0_last;
    sel_a         = gnt_q ? req1_a     : req0_a;
    sel_b         = gnt_q ? req1_b     : req0_b;
    sel_res_ready = gnt_q ? res1_ready : res0_ready;
  end

  assign beat_d = beat_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
      beat_q  <= '0;
      drain_q <= '0;
      mac_a_q <= '0;
      mac_b_q <= '0;
    end else begin
      // Zero operands by default so idle, bubble and drain cycles add nothing.
      mac_a_q <= '0;
      mac_b_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            gnt_q   <= pick;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          beat_q  <= '0;
          err_q   <= 1'b0;
          state_q <= STREAM;
        end
        STREAM: begin
          if (sel_valid) begin
            mac_a_q <= sel_a;
            mac_b_q <= sel_b;
            beat_q  <= beat_d;
            drain_q <= '0;
            if (sel_last) begin
              state_q <= DRAIN;
            end else if (beat_d == CNT_W'(MAX_LEN)) begin
              err_q   <= 1'b1;
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The final pair is already registered at the mac inputs; wait
          // for it to land in the accumulator.
          drain_q <= drain_q + 1'b1;
          if (drain_q == DRAIN_W'(MAC_LAT - 1)) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          if (sel_res_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_clr_n = rst && (state_q != CLEAR);

  assign req0_ready = (state_q == STREAM) && !gnt_q;
  assign req1_ready = (state_q == STREAM) &&  gnt_q;

  // Only zeros are fed during RESP, so mac_op is stable while a result waits.
  assign res0_valid = (state_q == RESP) && !gnt_q;
  assign res1_valid = (state_q == RESP) &&  gnt_q;
  assign res0_data  = res0_valid ? mac_op : '0;
  assign res1_data  = res1_valid ? mac_op : '0;
  assign res0_err   = res0_valid && err_q;
  assign res1_err   = res1_valid && err_q;

endmodule

// File: tb/tb_mac_job_arbiter.sv
module tb_mac_job_arbiter;
  import mac_pkg::*;

  localparam int TB_MAX = 4;
  localparam int NJ     = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]         req_valid;
  logic [1:0]         req_last;
  logic [1:0]         res_ready;
  logic [1:0][15:0]   req_a;
  logic [1:0][15:0]   req_b;
  wire  [1:0]         req_ready;
  wire  [1:0]         res_valid;
  wire  [1:0]         res_err;
  wire  [1:0][15:0]   res_data;
  wire  [15:0]        mac_a;
  wire  [15:0]        mac_b;
  wire                mac_clr_n;
  logic [15:0]        acc;

  mac_job_arbiter #(.MAX_LEN(TB_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req_valid[0]),
    .req0_ready (req_ready[0]),
    .req0_a     (req_a[0]),
    .req0_b     (req_b[0]),
    .req0_last  (req_last[0]),
    .res0_valid (res_valid[0]),
    .res0_ready (res_ready[0]),
    .res0_data  (res_data[0]),
    .res0_err   (res_err[0]),
    .req1_valid (req_valid[1]),
    .req1_ready (req_ready[1]),
    .req1_a     (req_a[1]),
    .req1_b     (req_b[1]),
    .req1_last  (req_last[1]),
    .res1_valid (res_valid[1]),
    .res1_ready (res_ready[1]),
    .res1_data  (res_data[1]),
    .res1_err   (res_err[1]),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_clr_n  (mac_clr_n),
    .mac_op     (acc)
  );

  // Stand-in for the shared mac: one-cycle accumulate, synchronous clear.
  always @(posedge clk) begin
    if (!mac_clr_n) acc <= '0;
    else            acc <= acc + mac_a * mac_b;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int               r;
    int               n;
    bit               lst;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [15:0]      exp_d;
    bit               exp_e;
  } vec_t;

  function automatic vec_t mk(input int r, input int n, input bit lst,
                              input logic [15:0] a0, b0, a1, b1, a2, b2, a3, b3,
                              input logic [15:0] ed, input bit ee);
    vec_t v;
    v.r = r; v.n = n; v.lst = lst;
    v.a[0] = a0; v.b[0] = b0; v.a[1] = a1; v.b[1] = b1;
    v.a[2] = a2; v.b[2] = b2; v.a[3] = a3; v.b[3] = b3;
    v.exp_d = ed; v.exp_e = ee;
    return v;
  endfunction

  // Present one pair (called at a negedge), wait for acceptance, return
  // at the negedge after the transfer edge with valid dropped.
  task automatic send_pair(input int r, input logic [15:0] a, input logic [15:0] b, input bit last);
    int t;
    t = 0;
    req_a[r] = a; req_b[r] = b; req_last[r] = last; req_valid[r] = 1'b1;
    while (!req_ready[r] && t < 300) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("ready_wait_r%0d", r), 32'(req_ready[r]), 32'd1);
    @(negedge clk);
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  task automatic send_job(input int r, input int n, input bit lst,
                          input logic [3:0][15:0] a, input logic [3:0][15:0] b, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap) @(negedge clk);
      send_pair(r, a[i], b[i], lst && (i == n - 1));
    end
  endtask

  // Wait for a result, optionally checking the latency from the last send.
  task automatic collect(input string nm, input int r, input logic [15:0] ed, input bit ee,
                         input bit chk_lat, input int hold);
    int t;
    t = 0;
    while (!res_valid[r] && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (chk_lat) check({nm, "_lat"}, 32'(t), 32'(MAC_LAT));
    check({nm, "_vld"},  32'(res_valid[r]), 32'd1);
    check({nm, "_data"}, 32'(res_data[r]),  32'(ed));
    check({nm, "_err"},  32'(res_err[r]),   32'(ee));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({nm, "_hold_vld"},  32'(res_valid[r]), 32'd1);
      check({nm, "_hold_data"}, 32'(res_data[r]),  32'(ed));
    end
    res_ready[r] = 1'b1;
    @(negedge clk);
    res_ready[r] = 1'b0;
    check({nm, "_drop"}, 32'(res_valid[r]), 32'd0);
  endtask

  // Reference model for random jobs: expected {err, sum mod 2^16} per requester.
  logic [16:0] q0[$];
  logic [16:0] q1[$];

  task automatic rdrive(input int r);
    for (int j = 0; j < NJ; j++) begin
      int          len;
      bit          wl;
      logic [15:0] s;
      logic [3:0][15:0] a;
      logic [3:0][15:0] b;
      len = $urandom_range(1, TB_MAX);
      wl  = (len < TB_MAX) ? 1'b1 : 1'($urandom_range(0, 1));
      s   = '0;
      for (int i = 0; i < len; i++) begin
        a[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
        b[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
        s    = s + a[i] * b[i];
      end
      if (r == 0) q0.push_back({!wl, s});
      else        q1.push_back({!wl, s});
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_pair(r, a[i], b[i], wl && (i == len - 1));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic rcollect(input int r);
    for (int j = 0; j < NJ; j++) begin
      int          t;
      int          qs;
      logic [16:0] e;
      t = 0;
      while (!res_valid[r] && t < 400) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("rnd_r%0d_vld", r), 32'(res_valid[r]), 32'd1);
      if (!res_valid[r]) return;
      qs = (r == 0) ? q0.size() : q1.size();
      check($sformatf("rnd_r%0d_pending", r), 32'(qs > 0), 32'd1);
      if (qs == 0) return;
      e = (r == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("rnd_r%0d_j%0d_data", r, j), 32'(res_data[r]), 32'(e[15:0]));
      check($sformatf("rnd_r%0d_j%0d_err", r, j),  32'(res_err[r]),  32'(e[16]));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      res_ready[r] = 1'b1;
      @(negedge clk);
      res_ready[r] = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t vt[7];
  int   t0a, t0b, t1;
  logic seen;

  initial begin
    logic [3:0][15:0] ja;
    logic [3:0][15:0] jb;

    vt[0] = mk(0, 2, 1, 16'd3, 16'd4, 16'd5, 16'd6, 16'd0, 16'd0, 16'd0, 16'd0, 16'd42, 0);
    vt[1] = mk(0, 4, 0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd4, 1);
    vt[2] = mk(0, 2, 1, 16'h0100, 16'h0100, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'h0001, 0);
    vt[3] = mk(1, 4, 1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd1, 16'd1, 16'd10, 16'd10, 16'd127, 0);
    vt[4] = mk(1, 1, 1, 16'hffff, 16'hffff, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'h0001, 0);
    vt[5] = mk(0, 3, 1, 16'd100, 16'd200, 16'd300, 16'd2, 16'd0, 16'd5, 16'd0, 16'd0, 16'd20600, 0);
    vt[6] = mk(1, 4, 0, 16'h1234, 16'd2, 16'd3, 16'd3, 16'd1, 16'd0, 16'd5, 16'd5, 16'h248A, 1);

    rst = 1'b0;
    req_valid = '0; req_last = '0; res_ready = '0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    check("rst_clr_n",  32'(mac_clr_n), 32'd0);
    check("rst_ready",  32'(req_ready), 32'd0);
    check("rst_valid",  32'(res_valid), 32'd0);
    check("rst_err",    32'(res_err),   32'd0);
    check("rst_mac_a",  32'(mac_a),     32'd0);
    check("rst_mac_b",  32'(mac_b),     32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_clr_n", 32'(mac_clr_n), 32'd1);
    check("idle_ready", 32'(req_ready), 32'd0);

    // Single-requester jobs from the table.
    for (int i = 0; i < 7; i++) begin
      send_job(vt[i].r, vt[i].n, vt[i].lst, vt[i].a, vt[i].b, 0);
      check($sformatf("v%0d_ready_after_last", i), 32'(req_ready), 32'd0);
      collect($sformatf("v%0d", i), vt[i].r, vt[i].exp_d, vt[i].exp_e, 1'b1, i % 3);
      @(negedge clk);
    end

    // Simultaneous requests: r0 first, then r1 before r0's next job.
    fork
      begin
        send_pair(0, 16'd1, 16'd1, 1'b1);
        collect("rr_r0a", 0, 16'd1, 1'b0, 1'b1, 0);
        t0a = cyc;
        send_pair(0, 16'd3, 16'd3, 1'b1);
        collect("rr_r0b", 0, 16'd9, 1'b0, 1'b1, 0);
        t0b = cyc;
      end
      begin
        send_pair(1, 16'd2, 16'd2, 1'b0);
        send_pair(1, 16'd7, 16'd1, 1'b1);
        collect("rr_r1", 1, 16'd11, 1'b0, 1'b1, 0);
        t1 = cyc;
      end
    join
    check("rr_r0_before_r1", 32'(t0a < t1), 32'd1);
    check("rr_r1_before_r0b", 32'(t1 < t0b), 32'd1);
    @(negedge clk);

    // Bubbles inside a requester 1 job.
    send_pair(1, 16'd10, 16'd10, 1'b0);
    check("bub_mac_a_xfer", 32'(mac_a), 32'd10);
    @(negedge clk);
    check("bub_mac_a_zero", 32'(mac_a), 32'd0);
    check("bub_mac_b_zero", 32'(mac_b), 32'd0);
    repeat (2) @(negedge clk);
    send_pair(1, 16'd1, 16'd1, 1'b1);
    collect("bub", 1, 16'd101, 1'b0, 1'b1, 0);
    @(negedge clk);

    // Reset in the middle of a requester 0 job.
    send_pair(0, 16'd7, 16'd7, 1'b0);
    req_a[0] = 16'd9; req_b[0] = 16'd9; req_valid[0] = 1'b1;
    rst = 1'b0;
    #1;
    check("mid_rst_clr_n", 32'(mac_clr_n), 32'd0);
    @(negedge clk);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_mac_a", 32'(mac_a), 32'd0);
    rst = 1'b1;
    req_valid[0] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | res_valid[0];
    end
    check("mid_rst_no_result", 32'(seen), 32'd0);
    ja = '0; jb = '0;
    ja[0] = 16'd2; jb[0] = 16'd3;
    send_job(0, 1, 1'b1, ja, jb, 0);
    collect("post_rst", 0, 16'd6, 1'b0, 1'b1, 0);
    @(negedge clk);

    // Randomized jobs from both requesters against the model.
    fork
      rdrive(0);
      rdrive(1);
      rcollect(0);
      rcollect(1);
    join

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_job_arbiter.md
Name: mac_job_arbiter

Overview:
- Shares one `mac` instance between two requesters.
- Each requester submits a "job": a stream of 16-bit operand pairs terminated by a last flag.
- The block arbitrates round-robin per job and clears the MAC accumulator before each job.
- It feeds operand pairs to the MAC, waits out the MAC latency, then returns the accumulated result to the winning requester.
- It sits directly above `mac` in the datapath hierarchy, driving its `a`, `b` and `rst` inputs and reading `op`.

Parameters:
- W, 16: operand and result width; matches the `mac` ports.
- MAC_LAT, 1: cycles from `a`/`b` valid at the `mac` inputs until `op` includes that product.
- MAX_LEN, 64: maximum operand pairs per job. A job is force-terminated at this count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0 pair accepted this cycle.
- req0_a  in  W  requester 0 operand a.
- req0_b  in  W  requester 0 operand b.
- req0_last  in  1  final pair of requester 0 job.
- res0_valid  out  1  result for requester 0 available.
- res0_ready  in  1  requester 0 accepts result.
- res0_data  out  W  accumulated result.
- res0_err  out  1  job hit MAX_LEN without last.
- req1_*, res1_*: same set of ports as requester 0, for requester 1.
- mac_a  out  W  to `mac.a`.
- mac_b  out  W  to `mac.b`.
- mac_clr_n  out  1  to `mac.rst`; synchronous active-low accumulator clear.
- mac_op  in  W  from `mac.op`.

Behaviour:
- **Reset** (rst=0 at a rising edge), including mid-job:
  - State returns to IDLE and the priority pointer goes to 0.
  - Beat counter and drain counter go to 0.
  - mac_a=0, mac_b=0.
  - All ready/valid/err outputs are 0.
  - mac_clr_n is 0 combinationally while rst=0.
  - An in-flight job is discarded; its result is never returned.
- **States**: IDLE, CLEAR, STREAM, DRAIN, RESP.
- **IDLE**:
  - If exactly one reqN_valid=1, grant N.
  - If both are valid, grant the requester selected by the pointer.
  - On any grant, the pointer is set to the non-granted requester.
  - Go to CLEAR. No ready is asserted in IDLE.
- **CLEAR**: one cycle. mac_clr_n=0, mac_a=mac_b=0, beat counter cleared. Go to STREAM.
- **STREAM**:
  - reqG_ready=1 for the granted requester only. The other requester's ready stays 0.
  - On a transfer (valid & ready): register mac_a/mac_b <= reqG_a/reqG_b and increment the beat counter.
  - On a non-transfer cycle: mac_a/mac_b <= 0, so a bubble adds 0 to the accumulator.
  - Transfer with last=1: go to DRAIN, err flag stays 0.
  - Transfer without last where the counter reaches MAX_LEN: go to DRAIN with the err flag set.
- **DRAIN**:
  - Lasts exactly MAC_LAT cycles, with mac_a=mac_b=0 and ready=0.
  - It must start after the final pair's mac_a/mac_b registration so that `op` includes the final product.
- **RESP**:
  - resG_valid=1, resG_data=mac_op (stable, since only zeros are being added), resG_err=err flag.
  - Held until resG_ready=1; the handshake cycle returns to IDLE.
  - A new grant is possible on the following cycle.
- **Latency**: the last pair accepted in cycle t gives resG_valid first high in cycle t+1+MAC_LAT.
  - Minimum job of 1 pair, requester 0 valid in cycle 0: grant in cycle 0, CLEAR in cycle 1, transfer in cycle 2, result in cycle 4 (MAC_LAT=1).
- **Arithmetic**:
  - The controller does not modify the data.
  - The accumulator wraps modulo 2^W inside `mac`; no saturation is applied.
- **Boundaries**:
  - last=1 exactly at beat MAX_LEN counts as normal termination; err=0.
  - Valid deasserted mid-job just stalls the job. There is no timeout.
  - The non-granted requester waits with its valid held. Its data is never sampled.
  - Requests arriving during CLEAR/STREAM/DRAIN/RESP are seen only in IDLE.

Decomposition:
- A shared package `mac_pkg` holds:
  - the state enum (IDLE, CLEAR, STREAM, DRAIN, RESP);
  - constants W and MAC_LAT;
  - the beat counter width, computed as clog2(MAX_LEN+1).
- One sub-module is natural: `rr_pick2`, a two-way round-robin picker with a pointer register. Its inputs are req[1:0] and advance; its outputs are grant index and grant_valid.
- The remaining FSM and datapath stay in `mac_job_arbiter`.

Test Plan:
1. Requester 0 job of (3,4),(5,6) with last on the 2nd pair → res0_data=42, res0_err=0; res0_valid rises 2 cycles after the last transfer.
2. Both requesters valid in the same cycle after reset → requester 0 is served first. Requester 1 job (2,2),(7,1) then gives res1_data=11, and requester 0's next job is granted only after that.
3. Bubbles in requester 1 stream (valid low for 3 cycles between pairs (10,10) and (1,1)) → res1_data=101.
4. MAX_LEN=4, requester 0 sends 4 pairs of (1,1) with no last → res0_data=4, res0_err=1. Requester 0 ready is 0 after the 4th transfer.
5. Wrap-around with pairs (0x0100,0x0100),(1,1) → res0_data=0x0001.
6. rst=0 for one cycle during STREAM of a requester 0 job → no res0_valid. The next job (2,3) returns 6, proving the accumulator was cleared.
